ex_muldiv_iter: RTL

- Iterative RV64M multiply/divide unit in the EX stage.
- It is the requester side of the pipeline hazard handshake. It raises `stall_req_o`, which the pipeline controller consumes as its mul/div stall request, and it holds that request until the result is ready.
- It obeys `flush_i`, which is derived from the controller's flush vector for EX.
- It produces one result per accepted operation, which is handed to the EX→MEM path.

---
 rtl/muldiv_pkg.sv | 66 ++++++
 rtl/div_restoring_step.sv | 25 ++
 rtl/ex_muldiv_iter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative RV64M multiply/divide unit.
// Op encodings, FSM states, iteration counts and op-class helpers.
package muldiv_pkg;

  localparam int XLEN      = 64;
  localparam int MUL_ITERS = 64;
  localparam int DIV_ITERS = 64;
  localparam int W_ITERS   = 32;

  localparam logic [5:0] CNT_MUL = 6'(MUL_ITERS - 1);
  localparam logic [5:0] CNT_DIV = 6'(DIV_ITERS - 1);
  localparam logic [5:0] CNT_W   = 6'(W_ITERS - 1);

  localparam logic [3:0] OP_MUL    = 4'd0;
  localparam logic [3:0] OP_MULH   = 4'd1;
  localparam logic [3:0] OP_MULHSU = 4'd2;
  localparam logic [3:0] OP_MULHU  = 4'd3;
  localparam logic [3:0] OP_DIV    = 4'd4;
  localparam logic [3:0] OP_DIVU   = 4'd5;
  localparam logic [3:0] OP_REM    = 4'd6;
  localparam logic [3:0] OP_REMU   = 4'd7;
  localparam logic [3:0] OP_MULW   = 4'd8;
  localparam logic [3:0] OP_DIVW   = 4'd9;
  localparam logic [3:0] OP_DIVUW  = 4'd10;
  localparam logic [3:0] OP_REMW   = 4'd11;
  localparam logic [3:0] OP_REMUW  = 4'd12;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  function automatic logic op_is_w(input logic [3:0] op);
    return (op >= OP_MULW) && (op <= OP_REMUW);
  endfunction

  function automatic logic op_is_div(input logic [3:0] op);
    return ((op >= OP_DIV) && (op <= OP_REMU)) ||
           ((op >= OP_DIVW) && (op <= OP_REMUW));
  endfunction

  function automatic logic op_is_rem(input logic [3:0] op);
    return (op == OP_REM) || (op == OP_REMU) ||
           (op == OP_REMW) || (op == OP_REMUW);
  endfunction

  function automatic logic op_mul_hi(input logic [3:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_MULHU);
  endfunction

  function automatic logic op_s1_signed(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_MULH) ||
           (op == OP_MULHSU) || (op == OP_DIV) ||
           (op == OP_REM) || (op == OP_MULW) ||
           (op == OP_DIVW) || (op == OP_REMW);
  endfunction

  function automatic logic op_s2_signed(input logic [3:0] op);
    return op_s1_signed(op) && (op != OP_MULHSU);
  endfunction

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

endpackage

// File: rtl/div_restoring_step.sv
// One restoring-division iteration: shift in the next dividend bit,
// trial-subtract the divisor, keep or restore the partial remainder.
module div_restoring_step
  import muldiv_pkg::*;
(
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] dvd_i,
  input  logic [XLEN-1:0] dsr_i,
  output logic [XLEN-1:0] rem_o,
  output logic            q_o,
  output logic [XLEN-1:0] dvd_o
);

  logic [XLEN:0] sh;
  logic [XLEN:0] diff;

  always_comb begin
    sh    = {rem_i, dvd_i[XLEN-1]};
    diff  = sh - {1'b0, dsr_i};
    q_o   = ~diff[XLEN];
    rem_o = q_o ? diff[XLEN-1:0] : sh[XLEN-1:0];
    dvd_o = {dvd_i[XLEN-2:0], 1'b0};
  end

endmodule

// File: rtl/ex_muldiv_iter.sv
// Iterative RV64M multiply/divide for the EX stage; stalls the pipe
// until done. MULDIV_EARLY_OUT_EN ends multiplies once the multiplier runs out.
module ex_muldiv_iter
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  input  logic [3:0]  op_i,
  input  logic [63:0] src1_i,
  input  logic [63:0] src2_i,
  input  logic        flush_i,
  output logic        stall_req_o,
  output logic        result_valid_o,
  output logic [63:0] result_o,
  output logic        busy_o
);

  logic [1:0]   state_q, state_d;
  logic [5:0]   cnt_q, cnt_d;
  logic [3:0]   op_q, op_d;
  logic         neg_q, neg_d;
  logic         rneg_q, rneg_d;
  logic [127:0] acc_q, acc_d;
  logic [127:0] mcd_q, mcd_d;
  logic [63:0]  mlt_q, mlt_d;
  logic [63:0]  res_q, res_d;

  logic         start;
  logic         w_s, s1s, s2s, n1, n2, dz, ovf;
  logic [63:0]  x1, x2, m1, m2, spec_val;

  always_comb begin
    w_s = op_is_w(op_i);
    s1s = op_s1_signed(op_i);
    s2s = op_s2_signed(op_i);
    x1  = src1_i;
    x2  = src2_i;
    if (w_s) begin
      x1 = s1s ? sext32(src1_i[31:0]) : {32'd0, src1_i[31:0]};
      x2 = s2s ? sext32(src2_i[31:0]) : {32'd0, src2_i[31:0]};
    end
    n1  = s1s & x1[63];
    n2  = s2s & x2[63];
    m1  = n1 ? -x1 : x1;
    m2  = n2 ? -x2 : x2;
    dz  = op_is_div(op_i) & (x2 == 64'd0);
    ovf = op_is_div(op_i) & s1s & (x2 == '1) &
          (x1 == (w_s ? 64'hFFFF_FFFF_8000_0000
                      : 64'h8000_0000_0000_0000));
    if (op_is_rem(op_i))
      spec_val = dz ? (w_s ? sext32(src1_i[31:0]) : src1_i) : 64'd0;
    else
      spec_val = dz ? '1 : x1;
  end

  // Division reuses acc as {remainder, dividend/quotient}, divisor in mcd
  logic [63:0]  st_rem, st_dvd, mlt_nxt;
  logic         st_q;
  logic [127:0] mul_acc, div_acc, it_acc;

  div_restoring_step u_step (
    .rem_i (acc_q[127:64]),
    .dvd_i (acc_q[63:0]),
    .dsr_i (mcd_q[63:0]),
    .rem_o (st_rem),
    .q_o   (st_q),
    .dvd_o (st_dvd)
  );

  assign mul_acc = acc_q + (mlt_q[0] ? mcd_q : 128'd0);
  assign div_acc = {st_rem, st_dvd | {63'd0, st_q}};
  assign it_acc  = op_is_div(op_q) ? div_acc : mul_acc;
  assign mlt_nxt = {1'b0, mlt_q[63:1]};

  logic [127:0] prod;
  logic [63:0]  quo, rmd, raw, res_fix;
  logic         last;

  always_comb begin
    prod = neg_q ? -it_acc : it_acc;
    quo  = neg_q ? -it_acc[63:0] : it_acc[63:0];
    rmd  = rneg_q ? -it_acc[127:64] : it_acc[127:64];
    if (op_is_div(op_q))
      raw = op_is_rem(op_q) ? rmd : quo;
    else
      raw = op_mul_hi(op_q) ? prod[127:64] : prod[63:0];
    res_fix = op_is_w(op_q) ? sext32(raw[31:0]) : raw;
    last = (cnt_q == 6'd0);
`ifdef MULDIV_EARLY_OUT_EN
    last = last | (~op_is_div(op_q) & (mlt_nxt == 64'd0));
`endif
  end

  assign start = valid_i & ~flush_i & rst_n;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    acc_d   = acc_q;
    mcd_d   = mcd_q;
    mlt_d   = mlt_q;
    res_d   = res_q;
    unique case (1'b1)
      state_q == S_IDLE: begin
        if (start) begin
          op_d   = op_i;
          neg_d  = n1 ^ n2;
          rneg_d = n1;
          if (w_s)
            cnt_d = CNT_W;
          else
            cnt_d = op_is_div(op_i) ? CNT_DIV : CNT_MUL;
          if (op_is_div(op_i)) begin
            acc_d = {64'd0, w_s ? {m1[31:0], 32'd0} : m1};
            mcd_d = {64'd0, m2};
            mlt_d = 64'd0;
          end else begin
            acc_d = 128'd0;
            mcd_d = {64'd0, m1};
            mlt_d = m2;
          end
          if (dz | ovf) begin
            state_d = S_DONE;
            res_d   = spec_val;
          end else begin
            state_d = S_BUSY;
          end
        end
      end
      state_q == S_BUSY: begin
        acc_d = it_acc;
        mlt_d = mlt_nxt;
        cnt_d = cnt_q - 6'd1;
        if (!op_is_div(op_q))
          mcd_d = {mcd_q[126:0], 1'b0};
        if (last) begin
          state_d = S_DONE;
          res_d   = res_fix;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush_i)
      state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      op_q    <= 4'd0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      acc_q   <= 128'd0;
      mcd_q   <= 128'd0;
      mlt_q   <= 64'd0;
      res_q   <= 64'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      acc_q   <= acc_d;
      mcd_q   <= mcd_d;
      mlt_q   <= mlt_d;
      res_q   <= res_d;
    end
  end

  assign stall_req_o    = ~flush_i &
                          ((state_q == S_IDLE & start) |
                           (state_q == S_BUSY));
  assign result_valid_o = (state_q == S_DONE) & ~flush_i;
  assign result_o       = res_q;
  assign busy_o         = (state_q != S_IDLE);

endmodule
